result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 18 +
 rtl/result_collector_col_fifo.sv | 81 ++++++++
 rtl/result_collector.sv | 103 ++++++++++
 3 files changed

// File: rtl/result_collector_pkg.sv
// Shared types and array-wide defaults for the result collector.
// Provides the collector state enumeration and MATRIX/DATA size defaults.
package result_collector_pkg;

  localparam int MATRIX_SIZE_DEF = 2;
  localparam int DATA_SIZE_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic int idx_width(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/result_collector_col_fifo.sv
// Per-column de-skew FIFO: DW wide, DEPTH deep, synchronous active-low reset.
// Ports: clear/push/pop/din in; dout (head), full, empty, drop out.
module col_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop, do_push;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign dout   = mem_q[rd_q];
  assign do_pop = pop & ~empty;
  // A pop on the same edge frees the slot.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = nxt(wr_q);
      end
      if (do_pop) begin
        rd_d = nxt(rd_q);
      end
      cnt_d = cnt_q + CW'(do_push)
            - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Re-aligns skewed systolic column results into whole rows for downstream.
// Ports: start/col_valid/col_data/row_ready in; row_*/done/overflow out.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           general_enable,
  input  logic                           start,
  input  logic [MATRIX_SIZE-1:0]         col_valid,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
  input  logic                           row_ready,
  output logic                           row_valid,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] row_data,
  output logic [$clog2(MATRIX_SIZE):0]   row_index,
  output logic                           done,
  output logic                           overflow
);

  localparam int M  = MATRIX_SIZE;
  localparam int D  = DATA_SIZE;
  localparam int IW = $clog2(M) + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;

  logic [M-1:0]    full, empty, drop, push;
  logic [M*D-1:0]  head;
  logic            collect, clear, pop;

  assign collect = (state_q == COLLECT);
  // start wins over any push/pop in the same cycle.
  assign clear   = general_enable & start;
  assign push    = {M{general_enable & collect
                      & ~start}} & col_valid;
  assign pop     = general_enable & row_valid
                 & row_ready & ~start;

  assign row_valid = collect & ~|empty;
  assign row_data  = row_valid ? head : '0;
  assign row_index = idx_q;
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;

  for (genvar j = 0; j < M; j++) begin : g_col
    col_fifo #(
      .DW    (D),
      .DEPTH (M)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (push[j]),
      .pop   (pop),
      .din   (col_data[j*D +: D]),
      .dout  (head[j*D +: D]),
      .full  (full[j]),
      .empty (empty[j]),
      .drop  (drop[j])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      clear: begin
        state_d = COLLECT;
        idx_d   = '0;
        ovf_d   = 1'b0;
      end
      default: begin
        if (|drop) begin
          ovf_d = 1'b1;
        end
        if (pop) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(M - 1)) begin
            state_d = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
